fetch_unit: RTL and testbench

//  IF stage. Owns the PC register (PCF), issues instruction-memory requests and fills the IF/ID register.

---
 rtl/rv32i_pkg.sv | 37 +++
 rtl/fetch_skid_buf.sv | 61 ++++++
 rtl/fetch_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
//   Shared types and constants for the RV32I front end.
//
//   DPW            datapath / PC width
//   NOP_INSTR      canonical bubble instruction (addi x0,x0,0)
//   fetch_state_t  fetch FSM states
//   if_id_t        one IF/ID pipeline entry {instr, pc, valid}
//   if_id_bubble() builds a bubble entry while keeping a given PC field
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam int          DPW       = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,   // free to issue a request
        ST_WAIT = 2'd1,   // one request outstanding, response wanted
        ST_DROP = 2'd2    // one request outstanding, response is wrong-path
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]    instr;
        logic [DPW-1:0] pc;
        logic           valid;
    } if_id_t;

    // A bubble carries NOP so that downstream decode never sees garbage.
    function automatic if_id_t if_id_bubble(input logic [DPW-1:0] pc);
        if_id_t b;
        b.instr = NOP_INSTR;
        b.pc    = pc;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage : rv32i_pkg

// File: rtl/fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
//   One-entry holding register for an IF/ID entry that arrived while the
//   decode stage was stalled.
//
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-high reset (empties the buffer)
//   load_i   in   capture data_i and mark the buffer full
//   clear_i  in   empty the buffer (wins over load_i)
//   data_i   in   entry to capture
//   data_o   out  buffered entry (meaningful only while full_o)
//   full_o   out  buffer holds an entry
// ---------------------------------------------------------------------------
module fetch_skid_buf
    import rv32i_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   load_i,
    input  logic   clear_i,
    input  if_id_t data_i,
    output if_id_t data_o,
    output logic   full_o
);

    logic   full_q,  full_d;
    if_id_t entry_q, entry_d;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        full_d  = full_q;
        entry_d = entry_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d  = 1'b1;
            entry_d = data_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // NOTE: the payload is qualified by full_q, so it needs no reset; leaving
    // it out keeps the data flops plain.
    always_ff @(posedge clk_i) begin
        entry_q <= entry_d;
    end

    assign data_o = entry_q;
    assign full_o = full_q;

endmodule : fetch_skid_buf

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   IF stage: owns the PC (PCF), issues instruction-memory requests (at most
//   one outstanding), and fills the IF/ID register. A one-entry skid buffer
//   absorbs a response that arrives while decode is stalled. redirect_i loads
//   pc_next_i and flushes the wrong path; a response already in flight at
//   that moment is discarded when it returns.
//
//   Optional feature: define FETCH_PERF_CNT_EN to add fetch_cnt_o and
//   bubble_cnt_o performance counters. Without it those ports do not exist
//   and behaviour is otherwise identical.
//
//   clk_i            in   clock, rising edge
//   rst_i            in   asynchronous active-high reset
//   pc_next_i        in   PCNext from branch_unit
//   redirect_i       in   taken branch/jump: load pc_next_i, flush
//   stall_i          in   hold IF/ID
//   imem_req_ready_i in   imem accepts the request
//   imem_rsp_valid_i in   imem response valid
//   imem_rsp_data_i  in   fetched instruction
//   pcf_o            out  current PC (PCF)
//   imem_req_valid_o out  request valid
//   imem_req_addr_o  out  request address (= pcf_o)
//   instr_d_o        out  IF/ID instruction (NOP_INSTR when not valid)
//   pc_d_o           out  IF/ID PC
//   valid_d_o        out  IF/ID valid
//   fetch_cnt_o      out  [FETCH_PERF_CNT_EN] valid IF/ID loads
//   bubble_cnt_o     out  [FETCH_PERF_CNT_EN] bubble IF/ID loads
// ---------------------------------------------------------------------------
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [DPW-1:0] RESET_PC  = '0,
    parameter logic [31:0]    NOP_INSTR = rv32i_pkg::NOP_INSTR
)
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [DPW-1:0] pc_next_i,
    input  logic           redirect_i,
    input  logic           stall_i,
    input  logic           imem_req_ready_i,
    input  logic           imem_rsp_valid_i,
    input  logic [31:0]    imem_rsp_data_i,
    output logic [DPW-1:0] pcf_o,
    output logic           imem_req_valid_o,
    output logic [DPW-1:0] imem_req_addr_o,
    output logic [31:0]    instr_d_o,
    output logic [DPW-1:0] pc_d_o,
    output logic           valid_d_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]    fetch_cnt_o,
    output logic [31:0]    bubble_cnt_o
`endif
);

    fetch_state_t   state_q,  state_d;
    logic [DPW-1:0] pc_q,     pc_d;
    logic [DPW-1:0] req_pc_q, req_pc_d;   // PC of the outstanding request
    if_id_t         ifid_q,   ifid_d;

    logic   issue;       // request offered this cycle
    logic   req_fire;    // request handshake
    logic   rsp_take;    // a response for the right path is accepted
    logic   skid_load;
    logic   skid_clear;
    logic   skid_full;
    if_id_t skid_data;
    if_id_t rsp_entry;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_REQ: begin
                if (req_fire) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    // A response in the same cycle is simply dropped; if it
                    // has not come back yet it must be swallowed later.
                    state_d = imem_rsp_valid_i ? ST_REQ : ST_DROP;
                end else if (imem_rsp_valid_i) begin
                    state_d = req_fire ? ST_WAIT : ST_REQ;
                end
            end
            ST_DROP: begin
                // A further redirect does not matter here: the outstanding
                // response is wrong-path either way.
                if (imem_rsp_valid_i) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs / per-cycle decisions
    // -----------------------------------------------------------------------
    always_comb begin
        // A full skid blocks issue, so no more than one instruction can be
        // in flight or parked beyond IF/ID. In ST_WAIT a new request may only
        // go out in the cycle the current response is consumed directly.
        issue = !skid_full && !redirect_i &&
                ((state_q == ST_REQ) ||
                 ((state_q == ST_WAIT) && imem_rsp_valid_i && !stall_i));
        req_fire   = issue && imem_req_ready_i;
        rsp_take   = (state_q == ST_WAIT) && imem_rsp_valid_i && !redirect_i;
        skid_load  = rsp_take && stall_i;
        skid_clear = redirect_i || (skid_full && !stall_i);
    end

    assign imem_req_valid_o = issue && !rst_i;
    assign imem_req_addr_o  = pc_q;
    assign pcf_o            = pc_q;

    // -----------------------------------------------------------------------
    // PC and outstanding-request PC
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (req_fire) req_pc_d = pc_q;
        // pc_next_i wraps naturally at 2^DPW; misaligned values pass through.
        if (redirect_i || req_fire) pc_d = pc_next_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Skid buffer
    // -----------------------------------------------------------------------
    always_comb begin
        rsp_entry.instr = imem_rsp_data_i;
        rsp_entry.pc    = req_pc_q;
        rsp_entry.valid = 1'b1;
    end

    fetch_skid_buf u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (rsp_entry),
        .data_o  (skid_data),
        .full_o  (skid_full)
    );

    // -----------------------------------------------------------------------
    // IF/ID register: flush beats stall; a parked entry beats a fresh
    // response so program order is kept.
    // -----------------------------------------------------------------------
    always_comb begin
        ifid_d = ifid_q;
        if (redirect_i) begin
            ifid_d       = if_id_bubble(ifid_q.pc);
            ifid_d.instr = NOP_INSTR;
        end else if (!stall_i) begin
            if (skid_full) begin
                ifid_d = skid_data;
            end else if (rsp_take) begin
                ifid_d = rsp_entry;
            end else begin
                ifid_d       = if_id_bubble(ifid_q.pc);
                ifid_d.instr = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ifid_q.instr <= NOP_INSTR;
            ifid_q.pc    <= '0;
            ifid_q.valid <= 1'b0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign instr_d_o = ifid_q.instr;
    assign pc_d_o    = ifid_q.pc;
    assign valid_d_o = ifid_q.valid;

    // -----------------------------------------------------------------------
    // Optional performance counters
    // -----------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q,  fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Only cycles where IF/ID actually loads count; a flush without stall
    // loads a bubble and is counted as one.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!stall_i) begin
            if (ifid_d.valid) fetch_cnt_d  = fetch_cnt_q  + 32'd1;
            else              bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    // Counters absent in this build.
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit with a transaction-level reference model
//   (outstanding-request flag, wrong-path flag, skid queue) checked every
//   cycle, plus hand-computed literal expectations per scenario.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    import rv32i_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_next_i;
    logic        redirect_i;
    logic        stall_i;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic [31:0] pcf_o;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic [31:0] instr_d_o;
    logic [31:0] pc_d_o;
    logic        valid_d_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;
`endif

    // branch_unit stand-in
    logic        use_tgt;
    logic [31:0] tgt;
    assign pc_next_i = use_tgt ? tgt : pcf_o + 32'd4;

    fetch_unit dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .pc_next_i        (pc_next_i),
        .redirect_i       (redirect_i),
        .stall_i          (stall_i),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .pcf_o            (pcf_o),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .instr_d_o        (instr_d_o),
        .pc_d_o           (pc_d_o),
        .valid_d_o        (valid_d_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o      (fetch_cnt_o),
        .bubble_cnt_o     (bubble_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[23:0], 8'h6F};
    endfunction

    // -----------------------------------------------------------------------
    // Instruction memory: responds rsp_lat cycles after a handshake.
    // -----------------------------------------------------------------------
    int          rsp_lat;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;

    always @(posedge clk_i) begin
        #1;
        imem_rsp_valid_i = 1'b0;
        if (pend) begin
            if (pend_cnt <= 1) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = instr_of(pend_addr);
                pend             = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Reference model + per-cycle compare
    // -----------------------------------------------------------------------
    logic [31:0] m_pc;
    bit          m_in_flight;    // a request is out, response not yet seen
    bit          m_wrong;        // that request belongs to a flushed path
    logic [31:0] m_flight_pc;
    if_id_t      m_ifid;
    if_id_t      m_skid[$];
    int unsigned m_fetch;
    int unsigned m_bubble;

    bit          e_issue, e_hs, e_rsp, e_good;
    if_id_t      e_next;

    always @(negedge clk_i) begin
        if (rst_i) begin
            m_pc        = 32'h0;
            m_in_flight = 1'b0;
            m_wrong     = 1'b0;
            m_flight_pc = 32'h0;
            m_ifid      = '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};
            m_skid.delete();
            m_fetch     = 0;
            m_bubble    = 0;
            check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
            check("rst_valid_d",   32'(valid_d_o),        32'd0);
            check("rst_instr_d",   instr_d_o,             NOP_INSTR);
            check("rst_pc_d",      pc_d_o,                32'h0);
            check("rst_pcf",       pcf_o,                 32'h0);
        end else begin
            e_issue = (m_skid.size() == 0) && !redirect_i &&
                      (!m_in_flight || (!m_wrong && imem_rsp_valid_i && !stall_i));
            check("req_valid", 32'(imem_req_valid_o), 32'(e_issue));
            if (e_issue) check("req_addr", imem_req_addr_o, m_pc);
            check("pcf",     pcf_o,            m_pc);
            check("valid_d", 32'(valid_d_o),   32'(m_ifid.valid));
            check("instr_d", instr_d_o,        m_ifid.instr);
            if (m_ifid.valid) check("pc_d", pc_d_o, m_ifid.pc);
`ifdef FETCH_PERF_CNT_EN
            check("fetch_cnt",  fetch_cnt_o,  32'(m_fetch));
            check("bubble_cnt", bubble_cnt_o, 32'(m_bubble));
`endif
            e_hs   = e_issue && imem_req_ready_i;
            e_rsp  = m_in_flight && imem_rsp_valid_i;
            e_good = e_rsp && !m_wrong && !redirect_i;

            e_next = m_ifid;
            if (redirect_i) begin
                e_next.valid = 1'b0;
                e_next.instr = NOP_INSTR;
                m_skid.delete();
            end else if (!stall_i) begin
                if (m_skid.size() != 0) begin
                    e_next = m_skid.pop_front();
                end else if (e_good) begin
                    e_next = '{instr: instr_of(m_flight_pc), pc: m_flight_pc, valid: 1'b1};
                end else begin
                    e_next.valid = 1'b0;
                    e_next.instr = NOP_INSTR;
                end
            end else if (e_good) begin
                m_skid.push_back('{instr: instr_of(m_flight_pc), pc: m_flight_pc, valid: 1'b1});
            end
            if (!stall_i) begin
                if (e_next.valid) m_fetch++;
                else              m_bubble++;
            end
            m_ifid = e_next;

            if (e_rsp) begin
                m_in_flight = e_hs;
                m_wrong     = 1'b0;
            end else begin
                if (e_hs) m_in_flight = 1'b1;
                if (redirect_i && m_in_flight) m_wrong = 1'b1;
            end
            if (e_hs) m_flight_pc = m_pc;
            if (redirect_i || e_hs) m_pc = use_tgt ? tgt : m_pc + 32'd4;
        end

        if (!rst_i && imem_req_valid_o && imem_req_ready_i) begin
            pend      = 1'b1;
            pend_cnt  = rsp_lat;
            pend_addr = imem_req_addr_o;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Returns at the negedge of the cycle in which addr handshakes.
    task automatic wait_hs(input logic [31:0] addr);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            if (imem_req_valid_o && imem_req_ready_i && imem_req_addr_o == addr) seen = 1'b1;
        end
        check("wait_hs_in_time", 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst_i = 1'b1; redirect_i = 1'b0; stall_i = 1'b0; imem_req_ready_i = 1'b1;
        use_tgt = 1'b0; tgt = 32'h0; rsp_lat = 3;
        imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'h0;
        pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0;

        // ---- reset ----
        repeat (2) @(posedge clk_i);
        cyc();
        rst_i = 1'b0;                       // cycle A: request 0x0, response in A+3
        @(negedge clk_i);
        check("lit_first_req_valid", 32'(imem_req_valid_o), 32'd1);
        check("lit_first_req_addr",  imem_req_addr_o,       32'h0);
        cyc();
        #2 rst_i = 1'b1;                    // mid-cycle reset, transaction in flight
        #1;
        check("lit_async_pcf",       pcf_o,                 32'h0);
        check("lit_async_req_valid", 32'(imem_req_valid_o), 32'd0);
        check("lit_async_instr",     instr_d_o,             32'h0000_0013);
        cyc();
        rst_i = 1'b0; imem_req_ready_i = 1'b0;
        repeat (2) cyc();                   // stale response lands in A+3
        @(negedge clk_i);
        check("lit_stale_valid", 32'(valid_d_o), 32'd0);
        check("lit_stale_instr", instr_d_o,      32'h0000_0013);
        check("lit_stale_addr",  imem_req_addr_o, 32'h0);

        // ---- stream ----
        cyc(); imem_req_ready_i = 1'b1; rsp_lat = 1;
        repeat (2) cyc();
        @(negedge clk_i);
        check("lit_stream_pc0",  pc_d_o,          32'h0);
        check("lit_stream_v0",   32'(valid_d_o),  32'd1);
        check("lit_stream_i0",   instr_d_o,       32'h0000_006F);
        cyc(); @(negedge clk_i);
        check("lit_stream_pc4",  pc_d_o,          32'h4);
        cyc(); @(negedge clk_i);
        check("lit_stream_pc8",  pc_d_o,          32'h8);
        check("lit_stream_v8",   32'(valid_d_o),  32'd1);

        // ---- backpressure at 0x24 ----
        wait_hs(32'h20);
        cyc(); imem_req_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("lit_bp_addr", imem_req_addr_o, 32'h24);
            check("lit_bp_pcf",  pcf_o,           32'h24);
            check("lit_bp_rv",   32'(imem_req_valid_o), 32'd1);
            if (k == 1) check("lit_bp_pc_d", pc_d_o, 32'h20);
            if (k == 2) check("lit_bp_bubble", 32'(valid_d_o), 32'd0);
            cyc();
        end

        // ---- redirect while waiting ----
        imem_req_ready_i = 1'b1; rsp_lat = 3;   // 0x24 handshakes now
        cyc(); redirect_i = 1'b1; use_tgt = 1'b1; tgt = 32'h100;
        cyc(); redirect_i = 1'b0; use_tgt = 1'b0; rsp_lat = 1;
        @(negedge clk_i);
        check("lit_redir_valid", 32'(valid_d_o),        32'd0);
        check("lit_redir_rv",    32'(imem_req_valid_o), 32'd0);
        check("lit_redir_pcf",   pcf_o,                 32'h100);
        cyc(); @(negedge clk_i);
        check("lit_drop_rv",     32'(imem_req_valid_o), 32'd0);
        wait_hs(32'h100);
        check("lit_after_drop_valid", 32'(valid_d_o), 32'd0);

        // ---- stall when 0x10C response arrives ----
        wait_hs(32'h10C);
        cyc(); stall_i = 1'b1;
        @(negedge clk_i);
        check("lit_stall_rv",   32'(imem_req_valid_o), 32'd0);
        check("lit_stall_pc_d", pc_d_o,                32'h108);
        cyc(); @(negedge clk_i);
        check("lit_stall2_pc_d", pc_d_o,               32'h108);
        check("lit_stall2_v",    32'(valid_d_o),       32'd1);
        cyc(); stall_i = 1'b0;
        @(negedge clk_i);
        check("lit_release_pc_d", pc_d_o, 32'h108);
        cyc(); @(negedge clk_i);
        check("lit_skid_pc_d",  pc_d_o,         32'h10C);
        check("lit_skid_instr", instr_d_o,      32'h0001_0C6F);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            cyc(); @(negedge clk_i);
            if (valid_d_o && pc_d_o != 32'h10C) found = 1'b1;
        end
        check("lit_next_found", 32'(found), 32'd1);
        check("lit_next_pc_d",  pc_d_o,     32'h110);

        // ---- mixed directed pattern: stalls, backpressure, redirects,
        //      PC wrap and misaligned target ----
        for (int i = 0; i < 60; i++) begin
            cyc();
            imem_req_ready_i = (i % 5) != 3;
            stall_i          = ((i % 7) == 2) || ((i % 7) == 3);
            redirect_i       = (i % 11) == 6;
            use_tgt          = redirect_i;
            tgt              = (i == 17) ? 32'hFFFF_FFFC :
                               (i == 28) ? 32'h0000_0202 : 32'h200 + 32'(i) * 32'd8;
            rsp_lat          = (i % 3 == 0) ? 2 : 1;
        end
        cyc();
        imem_req_ready_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; use_tgt = 1'b0; rsp_lat = 1;
        repeat (10) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_fetch_unit
